// File: rtl/comparator_exerciser.sv
// Stimulus/response engine for a magnitude comparator.
// Sweeps every {a,b} pair, with b incrementing fastest. Each vector is held
// for SETTLE cycles and then sampled for one cycle. The returned flag triple
// is checked against {a>b, a==b, a<b}. The engine keeps a saturating error
// count and records the first failing vector.
//
// Handshake: start is a level sampled only in IDLE or DONE. busy is high from
// the start edge to the final sample edge. done and pass are then held until
// the next accepted start.
module comparator_exerciser #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic             o1_in,
    input  logic             o2_in,
    input  logic             o3_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam int IDX_W = 2 * WIDTH;
    // The settle counter only runs from 0 to SETTLE-1.
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fail_valid_q, fail_valid_d;
    logic [WIDTH-1:0] fail_a_q, fail_a_d;
    logic [WIDTH-1:0] fail_b_q, fail_b_d;

    logic [WIDTH-1:0] cur_a;
    logic [WIDTH-1:0] cur_b;
    logic [2:0]       exp_flags;
    logic             mismatch;

    // Golden model: only an exact 3-bit match counts as a pass.
    always_comb begin
        cur_a     = idx_q[IDX_W-1:WIDTH];
        cur_b     = idx_q[WIDTH-1:0];
        exp_flags = {cur_a > cur_b, cur_a == cur_b, cur_a < cur_b};
        mismatch  = ({o1_in, o2_in, o3_in} != exp_flags);
    end

    // Next-state and result update.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_a_d     = fail_a_q;
        fail_b_d     = fail_b_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_DRIVE;
                    idx_d        = '0;
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    fail_a_d     = '0;
                    fail_b_d     = '0;
                end
            end
            S_DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != {ERR_W{1'b1}}) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_a_d     = cur_a;
                        fail_b_d     = cur_b;
                    end
                end
                if (idx_q == {IDX_W{1'b1}}) begin
                    // The last vector stays on a_out/b_out while in DONE.
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = S_DRIVE;
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers. Reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_a_q     <= fail_a_d;
            fail_b_q     <= fail_b_d;
        end
    end

    assign a_out      = idx_q[IDX_W-1:WIDTH];
    assign b_out      = idx_q[WIDTH-1:0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_a     = fail_a_q;
    assign fail_b     = fail_b_q;

endmodule

// File: tb/tb_comparator_exerciser.sv
// Bench for comparator_exerciser driving a behavioural comparator with
// selectable faults. Results are checked against a table of known outcomes
// and against a reference model for randomly corrupted comparators.
module tb_comparator_exerciser;

  localparam int WIDTH     = 2;
  localparam int SETTLE    = 2;
  localparam int ERR_W     = 4;
  localparam int NV        = 1 << (2 * WIDTH);
  localparam int VEC_CYC   = SETTLE + 1;
  localparam int DONE_EDGE = NV * VEC_CYC;
  localparam int ERR_MAX   = (1 << ERR_W) - 1;
  localparam int LIMIT     = DONE_EDGE + 40;

  // Comparator behaviours
  localparam int M_GOOD    = 0;
  localparam int M_SWAP    = 1;
  localparam int M_O2_ZERO = 2;
  localparam int M_ALL0    = 3;
  localparam int M_RANDOM  = 4;
  localparam int M_O1_ONE  = 5;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             o1_in;
  logic             o2_in;
  logic             o3_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             fail_valid;
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;

  int tests = 0;
  int fails = 0;

  // Flag triple {o1,o2,o3} returned for each vector index a*2^W+b.
  logic [2:0] resp [0:NV-1];

  typedef struct {
    int mode;
    int err;
    int fv;
    int fa;
    int fb;
    int pass;
  } vec_t;

  vec_t tbl [0:4];

  comparator_exerciser #(
    .WIDTH (WIDTH),
    .SETTLE(SETTLE),
    .ERR_W (ERR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_out     (a_out),
    .b_out     (b_out),
    .o1_in     (o1_in),
    .o2_in     (o2_in),
    .o3_in     (o3_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_valid(fail_valid),
    .fail_a    (fail_a),
    .fail_b    (fail_b)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural comparator under test
  always_comb begin
    {o1_in, o2_in, o3_in} = resp[{a_out, b_out}];
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_resp(input int mode);
    for (int v = 0; v < NV; v++) begin
      int a;
      int b;
      logic [2:0] gold;
      a = v / (1 << WIDTH);
      b = v % (1 << WIDTH);
      gold = {a > b, a == b, a < b};
      case (mode)
        M_SWAP:    resp[v] = {a < b, a == b, a > b};
        M_O2_ZERO: resp[v] = {a > b, 1'b0, a < b};
        M_ALL0:    resp[v] = 3'b000;
        M_O1_ONE:  resp[v] = {1'b1, a == b, a < b};
        M_RANDOM:  resp[v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : gold;
        default:   resp[v] = gold;
      endcase
    end
  endtask

  // Reference: count vectors whose response differs from the true ordering.
  task automatic model(output int err, output int fv, output int fa, output int fb,
                       output int ps);
    int n;
    n  = 0;
    fv = 0;
    fa = 0;
    fb = 0;
    for (int v = 0; v < NV; v++) begin
      int a;
      int b;
      a = v / (1 << WIDTH);
      b = v % (1 << WIDTH);
      if (resp[v] != {a > b, a == b, a < b}) begin
        if (fv == 0) begin
          fv = 1;
          fa = a;
          fb = b;
        end
        n++;
      end
    end
    err = (n > ERR_MAX) ? ERR_MAX : n;
    ps  = (n == 0) ? 1 : 0;
  endtask

  // Start a sweep, follow it to done and check the results.
  // If poke is set, a second start is pulsed mid-sweep at edge 10.
  task automatic run_sweep(input string tag, input int exp_err, input int exp_fv,
                           input int exp_fa, input int exp_fb, input int exp_pass,
                           input bit poke);
    int  done_k;
    bit  seq_ok;
    int  err_hold;
    done_k = -1;
    seq_ok = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_start_busy"}, int'(busy), 1);
    check({tag, "_start_clear"}, int'({done, pass, fail_valid}) + int'(err_count), 0);
    for (int k = 1; k <= LIMIT; k++) begin
      int exp_idx;
      @(posedge clk);
      #1;
      if (poke && k == 11) start = 1'b0;
      exp_idx = (k / VEC_CYC > NV - 1) ? NV - 1 : k / VEC_CYC;
      if (int'({a_out, b_out}) != exp_idx) seq_ok = 1'b0;
      if (done) begin
        done_k = k;
        break;
      end
      if (!busy) seq_ok = 1'b0;
      if (poke && k == 10) start = 1'b1;
    end
    if (done_k < 0) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    check({tag, "_ab_sequence"}, int'(seq_ok), 1);
    check({tag, "_done_edge"}, done_k, DONE_EDGE);
    check({tag, "_busy_end"}, int'(busy), 0);
    check({tag, "_err"}, int'(err_count), exp_err);
    check({tag, "_fail_valid"}, int'(fail_valid), exp_fv);
    if (exp_fv != 0) begin
      check({tag, "_fail_a"}, int'(fail_a), exp_fa);
      check({tag, "_fail_b"}, int'(fail_b), exp_fb);
    end
    check({tag, "_pass"}, int'(pass), exp_pass);
    err_hold = int'(err_count);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold"}, int'({done, pass}), int'({1'b1, exp_pass[0]}));
    check({tag, "_hold_err"}, int'(err_count), err_hold);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e;
    int fv;
    int fa;
    int fb;
    int ps;
    bit seen_done;

    tbl[0] = '{mode: M_GOOD,    err: 0,  fv: 0, fa: 0, fb: 0, pass: 1};
    tbl[1] = '{mode: M_SWAP,    err: 12, fv: 1, fa: 0, fb: 1, pass: 0};
    tbl[2] = '{mode: M_O2_ZERO, err: 4,  fv: 1, fa: 0, fb: 0, pass: 0};
    tbl[3] = '{mode: M_ALL0,    err: 15, fv: 1, fa: 0, fb: 0, pass: 0};
    tbl[4] = '{mode: M_O1_ONE,  err: 10, fv: 1, fa: 0, fb: 0, pass: 0};

    rst_n = 1'b0;
    start = 1'b0;
    fill_resp(M_GOOD);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          int'({busy, done, pass, fail_valid}) + int'(err_count) + int'({a_out, b_out})
          + int'({fail_a, fail_b}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_start", int'({busy, done}), 0);

    // Known-outcome sweeps; the all-zero case runs from DONE to exercise restart.
    foreach (tbl[i]) begin
      fill_resp(tbl[i].mode);
      run_sweep($sformatf("tbl%0d", i), tbl[i].err, tbl[i].fv, tbl[i].fa, tbl[i].fb,
                tbl[i].pass, 1'b0);
    end

    // start while busy is ignored
    fill_resp(M_GOOD);
    run_sweep("poke", 0, 0, 0, 0, 1, 1'b1);

    // Randomly corrupted comparators vs the reference model
    for (int r = 0; r < 4; r++) begin
      fill_resp(M_RANDOM);
      model(e, fv, fa, fb, ps);
      run_sweep($sformatf("rnd%0d", r), e, fv, fa, fb, ps, 1'b0);
    end

    // Asynchronous reset in the middle of a sweep
    fill_resp(M_ALL0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2 * VEC_CYC) @(posedge clk);
    #1;
    check("mid_idx_before_reset", int'({a_out, b_out}), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          int'({busy, done, pass, fail_valid}) + int'(err_count) + int'({a_out, b_out}), 0);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < DONE_EDGE + 10; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("no_activity_after_reset", int'(seen_done), 0);
    fill_resp(M_GOOD);
    run_sweep("post_reset", 0, 0, 0, 0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/comparator_exerciser.md
Name: comparator_exerciser

Overview:
- Self-checking stimulus/response engine for the other end of the comparator interface: drives a/b into a magnitude comparator and reads back its o1/o2/o3 flags.
- Sweeps every input combination exhaustively, waits a programmable settle time, and checks each flag triple against an internal golden model.
- Reports error count, first failing vector and a pass flag.
- Used as an on-chip BIST and as a reusable bench driver for the comparator family.

Parameters:
- WIDTH, 1, bit width of a_out/b_out (comparator operand width).
- SETTLE, 1, cycles each vector is held before sampling; legal range >=1.
- ERR_W, 8, width of err_count.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- a_out  output  WIDTH  operand A to comparator.
- b_out  output  WIDTH  operand B to comparator.
- o1_in  input  1  comparator flag, a>b.
- o2_in  input  1  comparator flag, a==b.
- o3_in  input  1  comparator flag, a<b.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; held until the next start.
- pass  output  1  done and err_count==0.
- err_count  output  ERR_W  mismatching vectors, saturating.
- fail_valid  output  1  a mismatch has been captured.
- fail_a  output  WIDTH  A of the first failing vector.
- fail_b  output  WIDTH  B of the first failing vector.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; vector index idx=0; settle counter=0.
- idx is 2*WIDTH bits wide. a_out=idx[2W-1:W] and b_out=idx[W-1:0], driven from registers. Sweep order: (0,0),(0,1),(0,2)... with b incrementing fastest.
- Golden model: expected {o1,o2,o3} = {a>b, a==b, a<b}, unsigned. A check passes only on an exact 3-bit match, so zero or multiple flags high counts as a mismatch.
- IDLE: start=1 at an edge gives state=DRIVE, idx=0, busy=1, err_count=0, fail_valid=0, settle counter=0.
- DRIVE: counter increments each edge. After SETTLE edges in DRIVE, go to SAMPLE.
- SAMPLE (one cycle): at its edge, compare o*_in against the model for the current a_out/b_out.
  - On mismatch: err_count+1, saturating at all-ones.
  - If fail_valid==0: capture fail_a/fail_b and set fail_valid=1.
  - Same edge: if idx==2^(2W)-1, go to DONE; otherwise idx+1 and go to DRIVE with the counter cleared.
- Each vector occupies SETTLE+1 cycles. done rises exactly 2^(2W)*(SETTLE+1) edges after the start edge.
- DONE: busy=0, done=1, pass=(err_count==0). a_out/b_out hold the last vector.
  - start=1 restarts the sweep with the IDLE-entry actions; done and pass clear on that edge.
- start while busy is ignored, with no restart and no effect on counters.
- Results (err_count, fail_*, pass) stay stable from done until the next start or reset.
- Reset mid-sweep aborts immediately: all state and outputs return to reset values and no partial result is retained.

Test Plan:
- Correct 1-bit comparator, WIDTH=1, SETTLE=1, start pulsed one cycle -> busy for 8 cycles, done=1 on 8th edge after start, pass=1, err_count=0, fail_valid=0; a_out/b_out sequence 00,01,10,11 each held 2 cycles.
- o1/o3 swapped in DUT model -> err_count=2, fail_valid=1, fail_a=0, fail_b=1, pass=0.
- o2 stuck at 0 -> err_count=2 (vectors 00 and 11), fail_a=0, fail_b=0, pass=0.
- WIDTH=2, SETTLE=3, correct comparator -> 16 vectors, done 64 edges after start, pass=1. Second start while busy at cycle 10 ignored, so done is still at edge 64.
- ERR_W=2, WIDTH=2, all flags stuck 0 -> err_count saturates at 3, fail at (0,0). Start from DONE -> err_count clears to 0 next edge and sweep restarts from idx=0.
- rst_n pulsed low for 1 ns mid-sweep (idx=2) -> outputs 0 asynchronously, state IDLE, no done. A later start gives a full clean sweep with pass=1.
